// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants used by the fetch front end.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

    // Fetch addresses are always word aligned, so the two low bits are dropped.
    function automatic logic [ADDR_W-1:0] alignPc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush, used as the instruction fetch queue.
// Storage is not reset; only the pointers and the occupancy count are.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush;
    logic             doPop;

    // A pop of an empty FIFO is ignored; a push into a full FIFO only lands when a pop frees the slot.
    always_comb begin
        doPop   = pop_i & (count_q != '0);
        doPush  = push_i & ((count_q != DEPTH_C) | doPop);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            if (doPush && !doPop) begin
                count_d = count_q + CW'(1);
            end else if (doPop && !doPush) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and occupancy registers; reset wins over flush and traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; when full with a pop the tail equals the head being read out this cycle.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the fetch PC, handles redirects and
// buffers fetched {pc, instr} pairs in a small queue for the decode stage.
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int QDEPTH = 4,
    localparam int CW = $clog2(QDEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  im_pc,
    input  logic [INSTR_W-1:0] im_code,
    input  logic               fetch_en,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [CW-1:0]      q_count
);

    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  fetchPc_q, fetchPc_d;
    logic               pop;
    logic               push;
    logic [ENTRY_W-1:0] headEntry;
    logic [CW-1:0]      count;

    // Handshake qualification: the decode stage consumes the head, and a fetch lands only if there is room.
    always_comb begin
        pop  = out_valid & out_ready;
        push = fetch_en & ~redirect & ((count < QDEPTH_C) | pop);
    end

    // Next fetch address: a redirect overrides everything, otherwise step one word per accepted fetch.
    always_comb begin
        fetchPc_d = fetchPc_q;
        if (redirect) begin
            fetchPc_d = alignPc(redirect_pc);
        end else if (push) begin
            fetchPc_d = fetchPc_q + PC_INC;
        end
    end

    // Fetch PC register; reset has priority over redirect and fetch progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetchPc_q <= RESET_PC;
        end else begin
            fetchPc_q <= fetchPc_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({fetchPc_q, im_code}),
        .rdata_o (headEntry),
        .count_o (count)
    );

    // Head presentation: zeros whenever the queue is empty so stale storage never leaks out.
    always_comb begin
        out_valid = (count != '0);
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc    = headEntry[ENTRY_W-1:INSTR_W];
            out_instr = headEntry[INSTR_W-1:0];
        end
    end

    assign im_pc   = fetchPc_q;
    assign q_count = count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed vector table plus a reference-model run for the fetch queue.
module tb_ifetch_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] im_pc;
    logic [31:0] im_code;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  q_count;

    int numCompared;
    int numMismatched;

    typedef struct {
        logic        rstN;
        logic        fetchEn;
        logic        redir;
        logic [31:0] redirPc;
        logic        rdy;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [2:0]  expCount;
        logic [31:0] expImPc;
    } vec_t;

    vec_t vecs[$];

    ifetch_queue #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .im_pc       (im_pc),
        .im_code     (im_code),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .q_count     (q_count)
    );

    // Instruction memory: word k holds 32'h1000_0000 + k.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign im_code = memWord(im_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic fe, input logic rd, input logic [31:0] rpc,
                                input logic rdy, input logic v, input logic [31:0] pc,
                                input logic [2:0] cnt, input logic [31:0] impc);
        vec_t x;
        x.rstN     = r;
        x.fetchEn  = fe;
        x.redir    = rd;
        x.redirPc  = rpc;
        x.rdy      = rdy;
        x.expValid = v;
        x.expPc    = v ? pc : 32'h0;
        x.expInstr = v ? memWord(pc) : 32'h0;
        x.expCount = cnt;
        x.expImPc  = impc;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compareOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        numCompared++;
        if (act !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [2:0] cnt, input logic [31:0] impc);
        compareOne({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
        compareOne({tag, ".out_pc"}, out_pc, pc);
        compareOne({tag, ".out_instr"}, out_instr, instr);
        compareOne({tag, ".q_count"}, {29'b0, q_count}, {29'b0, cnt});
        compareOne({tag, ".im_pc"}, im_pc, impc);
    endtask

    task automatic applyStimulus(input logic r, input logic fe, input logic rd,
                                 input logic [31:0] rpc, input logic rdy);
        rst_n       = r;
        fetch_en    = fe;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
    endtask

    // Reference-model state for the random run.
    logic [63:0] modelQ[$];
    logic [31:0] modelPc;

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("reset", 1'b0, 32'h0, 32'h0, 3'd0, 32'h0);

        // Fill, hold full, drain at full rate, redirect, wrap, reset mid-run.
        vecs.push_back(mk(0,1,0,32'h0,0, 0,32'h0,        3'd0, 32'h0));
        vecs.push_back(mk(1,1,0,32'h0,0, 1,32'h0,        3'd1, 32'h4));
        vecs.push_back(mk(1,1,0,32'h0,0, 1,32'h0,        3'd2, 32'h8));
        vecs.push_back(mk(1,1,0,32'h0,0, 1,32'h0,        3'd3, 32'hC));
        vecs.push_back(mk(1,1,0,32'h0,0, 1,32'h0,        3'd4, 32'h10));
        vecs.push_back(mk(1,1,0,32'h0,0, 1,32'h0,        3'd4, 32'h10));
        vecs.push_back(mk(1,1,0,32'h0,1, 1,32'h4,        3'd4, 32'h14));
        vecs.push_back(mk(1,1,0,32'h0,1, 1,32'h8,        3'd4, 32'h18));
        vecs.push_back(mk(1,0,0,32'h0,1, 1,32'hC,        3'd3, 32'h18));
        vecs.push_back(mk(1,0,0,32'h0,0, 1,32'hC,        3'd3, 32'h18));
        vecs.push_back(mk(1,1,1,32'h102,0, 0,32'h0,      3'd0, 32'h100));
        vecs.push_back(mk(1,1,0,32'h0,0, 1,32'h100,      3'd1, 32'h104));
        vecs.push_back(mk(1,1,1,32'hFFFF_FFFF,1, 0,32'h0, 3'd0, 32'hFFFF_FFFC));
        vecs.push_back(mk(1,1,0,32'h0,0, 1,32'hFFFF_FFFC, 3'd1, 32'h0));
        vecs.push_back(mk(1,1,0,32'h0,1, 1,32'h0,        3'd1, 32'h4));
        vecs.push_back(mk(1,1,0,32'h0,0, 1,32'h0,        3'd2, 32'h8));
        vecs.push_back(mk(0,1,0,32'h0,1, 0,32'h0,        3'd0, 32'h0));
        vecs.push_back(mk(1,0,0,32'h0,1, 0,32'h0,        3'd0, 32'h0));
        vecs.push_back(mk(1,1,0,32'h0,1, 1,32'h0,        3'd1, 32'h4));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].fetchEn, vecs[i].redir, vecs[i].redirPc, vecs[i].rdy);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                        vecs[i].expInstr, vecs[i].expCount, vecs[i].expImPc);
        end

        // Redirect then wait (bounded) for the queue to fill from the new target.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        begin
            int cycles;
            cycles = 0;
            while (q_count != 3'd4 && cycles < 10) begin
                tick();
                cycles++;
            end
            compareOne("fill_bound", {31'b0, (q_count == 3'd4)}, 32'h1);
            compareOne("fill_cycles", cycles, 4);
        end
        checkOutput("fill_full", 1'b1, 32'h200, memWord(32'h200), 3'd4, 32'h210);

        // Random traffic checked against a queue model; resynchronise with a reset first.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        modelQ.delete();
        modelPc = 32'h0;
        for (int c = 0; c < 4000; c++) begin
            logic fe, rdy, rd, mPop, mPush;
            logic [31:0] rpc;
            logic [63:0] head;
            fe  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) != 0);
            rd  = ($urandom_range(0, 63) == 0);
            rpc = $urandom;
            applyStimulus(1'b1, fe, rd, rpc, rdy);
            mPop  = (modelQ.size() != 0) && rdy;
            mPush = fe && !rd && ((modelQ.size() < 4) || mPop);
            if (rd) begin
                modelQ.delete();
                modelPc = {rpc[31:2], 2'b00};
            end else begin
                if (mPop) void'(modelQ.pop_front());
                if (mPush) begin
                    modelQ.push_back({modelPc, memWord(modelPc)});
                    modelPc = modelPc + 32'd4;
                end
            end
            tick();
            head = (modelQ.size() != 0) ? modelQ[0] : 64'h0;
            compareOne($sformatf("rand%0d.head", c), out_pc ^ out_instr ^ {29'b0, q_count},
                       head[63:32] ^ head[31:0] ^ modelQ.size());
            if (out_pc !== head[63:32] || out_instr !== head[31:0] || im_pc !== modelPc ||
                q_count !== 3'(modelQ.size()) || out_valid !== (modelQ.size() != 0)) begin
                numMismatched++;
                $display("[TB] FAIL rand%0d.state: got pc=%h instr=%h cnt=%0d impc=%h v=%b expected pc=%h instr=%h cnt=%0d impc=%h",
                         c, out_pc, out_instr, q_count, im_pc, out_valid,
                         head[63:32], head[31:0], modelQ.size(), modelPc);
            end
            numCompared++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
